qnna_requant: RTL
=================

Name: qnna_requant

Overview:
Output stage directly downstream of qnna_mac_array. Accepts the MAC array's stream of signed INT32 accumulators and requantizes each one to INT8 with:
- scale multiply
- rounding right shift
- zero-point add
- optional ReLU
- saturation

It packs four INT8 results per 32-bit word for the result buffer and Wishbone readback. Configuration comes from qnna_csr and is latched on the same start pulse that kicks the MAC array.

Parameters:
ACC_W, 32, accumulator input width (signed)
SCALE_W, 16, requant multiplier width (unsigned)
LANES, 4, INT8 results per output word (output width = 8*LANES)

Ports:
clk  in  1  core clock (wb_clk_i at top)
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latches cfg_*, flushes pipeline and packer
cfg_scale  in  SCALE_W  unsigned multiplier
cfg_shift  in  6  right-shift amount; values >47 treated as 47
cfg_zp  in  8  signed output zero point
cfg_relu  in  1  ReLU enable (csr_relu_en)
in_valid  in  1  accumulator valid
in_ready  out  1  accumulator accepted when in_valid && in_ready
in_acc  in  ACC_W  signed accumulator
in_last  in  1  marks final accumulator of the tile
out_valid  out  1  packed word valid
out_ready  in  1  downstream accept
out_data  out  8*LANES  packed INT8 results; lane 0 = bits[7:0] = earliest element
out_byte_en  out  LANES  valid-byte mask of out_data
out_last  out  1  word contains the tile's final element
sat_count  out  16  saturation event counter (see Optional Feature)

Behaviour:
- Reset: out_valid=0, out_data=0, out_byte_en=0, out_last=0, sat_count=0, all stage valids=0, packer count=0, cfg registers=0. in_ready=1 one cycle after reset deassertion.
- Pipeline: three registered stages.
  - S1: prod = in_acc * {1'b0,cfg_scale}; signed, ACC_W+SCALE_W+1 bits.
  - S2: requant byte.
  - S3: packer/output register.
- Global stall = out_valid && !out_ready. All stages hold on stall. in_ready = !stall; this is a combinational path from out_ready, which is documented and accepted.
- S2 arithmetic, in order:
  - r = (shift==0) ? prod : (prod + (1<<(shift-1))) >>> shift, i.e. round half toward +inf.
  - v = r + sign_ext(cfg_zp).
  - If relu: v = max(v, cfg_zp).
  - Saturate to [-128,127]; sat flag = clamp applied.
  - All intermediates at full width; no wrap.
- Packer: a byte entering S3 is written to lane[count] and count increments. The word is emitted (out_valid=1, count->0) when:
  - count reaches LANES, or
  - the byte carries last; unused lanes are 0, out_byte_en = mask of filled lanes, out_last=1.
- out_data/out_byte_en/out_last are held stable while out_valid && !out_ready.
- Latency: the 4th element accepted at cycle t gives out_valid high at t+3. Throughput is 1 element/cycle when out_ready is high.
- Simultaneous out handshake and new word completion: the new word loads the same cycle and out_valid stays 1.
- start at any time, including mid-tile:
  - Next cycle: all stage valids=0, count=0, out_valid=0; the partial word is discarded.
  - cfg_* are latched.
  - in_valid in the start cycle is ignored (in_ready=0 that cycle).
- rst mid-operation: same as reset values; no partial output.
- cfg_* inputs are not used between start pulses; only the latched copies are used.

Optional Feature:
Macro QNNA_RQ_SATCNT_EN.
- Defined: sat_count increments once per element whose S2 saturation clamp fired. It sticks at 0xFFFF and clears on start or rst.
- Not defined: sat_count tied to 0 and no counter logic is generated; the port is always present.

Decomposition:
- qnna_pkg holds:
  - ACC_W/SCALE_W defaults
  - INT8_MAX=127, INT8_MIN=-128
  - MAX_SHIFT=47
  - typedef of the packed output word
- One sub-module: qnna_rq_lane, the S1/S2 datapath (multiply, round-shift, zp, ReLU, saturate) with a valid/enable input.
- Packer, stall logic and counter stay in qnna_requant.

Test Plan:
1. Basic scaling: scale=16384, shift=16, zp=0, relu=0; acc=100,200,-100,4 then last -> one word 0x01E7_3219, be=0xF, last=1.
2. Rounding: scale=1, shift=2; acc=6 -> 2; acc=-6 -> -1 (0xFF); acc=5 -> 1 with last -> data 0x0001FF02, be=0x7.
3. Saturation: scale=1, shift=0; acc=1000 -> 0x7F; acc=-1000 -> 0x80; acc=127 -> 0x7F with last -> be=0x7, sat_count=2 with macro and 0 without.
4. ReLU + zp: zp=10, relu=1; acc=-50 -> 0x0A; acc=20 -> 0x1E, last -> data 0x00001E0A, be=0x3. With relu=0, -50 -> 0xD8.
5. Backpressure: stream 1..12 with last on 12; out_ready low 10 cycles mid-stream.
   - Expected: in_ready low while stalled, out_data stable.
   - Words 0x04030201, 0x08070605, 0x0C0B0A09 in order; last only on the third.
6. Abort: feed 1,2 (no last), pulse start, then feed 7 with last -> single word 0x00000007, be=0x1, last=1; no word contains 1 or 2.

Source files
------------

// File: rtl/qnna_pkg.sv
// rtl/qnna_pkg.sv - shared constants and types for the qnna requantizer
package qnna_pkg;

    localparam int ACC_W_DEF   = 32;
    localparam int SCALE_W_DEF = 16;
    localparam int LANES_DEF   = 4;

    localparam int INT8_MAX  = 127;
    localparam int INT8_MIN  = -128;
    localparam int MAX_SHIFT = 47;

    typedef logic [8*LANES_DEF-1:0] rq_word_t;

endpackage

// File: rtl/qnna_rq_lane.sv
// rtl/qnna_rq_lane.sv - S1/S2 datapath: scale multiply, round-shift, zero point, ReLU, saturate
module qnna_rq_lane
    import qnna_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int SCALE_W = SCALE_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    en,
    input  logic                    valid,
    input  logic signed [ACC_W-1:0] acc,
    input  logic                    last,
    input  logic [SCALE_W-1:0]      scale,
    input  logic [5:0]              shift,
    input  logic signed [7:0]       zp,
    input  logic                    relu,
    output logic                    res_valid,
    output logic [7:0]              res_data,
    output logic                    res_last,
    output logic                    res_sat
);

    // Product width covers signed acc times unsigned scale exactly; three
    // guard bits keep the rounding add and zero-point add from wrapping.
    localparam int PW = ACC_W + SCALE_W + 1;
    localparam int VW = PW + 3;

    logic                 s1_valid;
    logic                 s1_last;
    logic signed [PW-1:0] s1_prod;
    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] m_x;

    assign a_x = PW'(acc);
    assign m_x = PW'({1'b0, scale});

    // S1: register the scaled product
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_last  <= 1'b0;
        end else if (en) begin
            s1_valid <= valid;
            s1_prod  <= a_x * m_x;
            s1_last  <= last;
        end
    end

    logic [5:0]           sh;
    logic signed [VW-1:0] pw;
    logic signed [VW-1:0] rnd;
    logic signed [VW-1:0] r;
    logic signed [VW-1:0] zpx;
    logic signed [VW-1:0] v0;
    logic signed [VW-1:0] v;
    logic [7:0]           sat_data;
    logic                 sat_hit;

    // S2 arithmetic: round half toward +inf, add zero point, ReLU floor at zp, clamp to int8
    always_comb begin
        sh  = (shift > 6'(MAX_SHIFT)) ? 6'(MAX_SHIFT) : shift;
        pw  = VW'(s1_prod);
        zpx = VW'(zp);
        rnd = '0;
        r   = pw;
        if (sh != 6'd0) begin
            rnd[sh - 6'd1] = 1'b1;
            r = (pw + rnd) >>> sh;
        end
        v0 = r + zpx;
        v  = (relu && (v0 < zpx)) ? zpx : v0;
        sat_data = v[7:0];
        sat_hit  = 1'b0;
        if (v > VW'(INT8_MAX)) begin
            sat_data = 8'h7F;
            sat_hit  = 1'b1;
        end else if (v < VW'(INT8_MIN)) begin
            sat_data = 8'h80;
            sat_hit  = 1'b1;
        end
    end

    // S2: register the requantized byte
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
            res_sat   <= 1'b0;
        end else if (en) begin
            res_valid <= s1_valid;
            res_data  <= sat_data;
            res_last  <= s1_last;
            res_sat   <= sat_hit && s1_valid;
        end
    end

endmodule

// File: rtl/qnna_requant.sv
// rtl/qnna_requant.sv - INT32 to INT8 requantizer and 4-lane packer; QNNA_RQ_SATCNT_EN enables sat_count
module qnna_requant
    import qnna_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int SCALE_W = SCALE_W_DEF,
    parameter int LANES   = LANES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [SCALE_W-1:0]      cfg_scale,
    input  logic [5:0]              cfg_shift,
    input  logic [7:0]              cfg_zp,
    input  logic                    cfg_relu,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_acc,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*LANES-1:0]      out_data,
    output logic [LANES-1:0]        out_byte_en,
    output logic                    out_last,
    output logic [15:0]             sat_count
);

    localparam int CW = $clog2(LANES + 1);

    logic               stall;
    logic               fire;
    logic [SCALE_W-1:0] lat_scale;
    logic [5:0]         lat_shift;
    logic signed [7:0]  lat_zp;
    logic               lat_relu;

    // Whole pipeline freezes while a finished word waits downstream.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !rst && !start && !stall;
    assign fire     = in_valid && in_ready;

    // Configuration is captured only on start; live cfg inputs are ignored otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_scale <= '0;
            lat_shift <= '0;
            lat_zp    <= '0;
            lat_relu  <= 1'b0;
        end else if (start) begin
            lat_scale <= cfg_scale;
            lat_shift <= cfg_shift;
            lat_zp    <= cfg_zp;
            lat_relu  <= cfg_relu;
        end
    end

    logic       res_valid;
    logic [7:0] res_data;
    logic       res_last;
    logic       res_sat;

    qnna_rq_lane #(
        .ACC_W   (ACC_W),
        .SCALE_W (SCALE_W)
    ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .flush     (start),
        .en        (!stall),
        .valid     (fire),
        .acc       (in_acc),
        .last      (in_last),
        .scale     (lat_scale),
        .shift     (lat_shift),
        .zp        (lat_zp),
        .relu      (lat_relu),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_last  (res_last),
        .res_sat   (res_sat)
    );

    logic [8*LANES-1:0] pk_buf;
    logic [8*LANES-1:0] pk_word;
    logic [LANES-1:0]   pk_mask;
    logic [CW-1:0]      count;
    logic [CW-1:0]      pk_next;
    logic               pk_done;

    // Merge the incoming byte into the partial word and decide whether it completes
    always_comb begin
        pk_word = pk_buf;
        pk_word[8*count +: 8] = res_data;
        pk_next = count + CW'(1);
        pk_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            pk_mask[i] = (i < int'(pk_next));
        end
        pk_done = (pk_next == CW'(LANES)) || res_last;
    end

    // Packer and output register; a completing word may reload in the same cycle as a handshake
    always_ff @(posedge clk) begin
        if (rst || start) begin
            pk_buf      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_byte_en <= '0;
            out_last    <= 1'b0;
        end else if (!stall) begin
            out_valid <= 1'b0;
            if (res_valid) begin
                if (pk_done) begin
                    out_data    <= pk_word;
                    out_byte_en <= pk_mask;
                    out_last    <= res_last;
                    out_valid   <= 1'b1;
                    pk_buf      <= '0;
                    count       <= '0;
                end else begin
                    pk_buf <= pk_word;
                    count  <= pk_next;
                end
            end
        end
    end

`ifdef QNNA_RQ_SATCNT_EN
    logic [15:0] sat_q;

    // Sticky saturation event counter, counted as each byte enters the packer
    always_ff @(posedge clk) begin
        if (rst || start) begin
            sat_q <= '0;
        end else if (!stall && res_valid && res_sat && (sat_q != 16'hFFFF)) begin
            sat_q <= sat_q + 16'd1;
        end
    end

    assign sat_count = sat_q;
`else
    logic unused_sat;

    assign unused_sat = res_sat;
    assign sat_count  = '0;
`endif

endmodule
